seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector with registered one-cycle match pulse, runtime-loadable pattern, runtime-selectable overlapping/non-overlapping mode, and saturating match counter. It is the general successor to the fixed 3-bit non-overlapping detectors in the sequential/fsm library. It sits on a qualified serial bit stream (one bit per `en` cycle) and drives downstream control logic and status registers.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..32.
- `PAT_RST`, default 4'b1010 (width PAT_W): pattern value after reset.
- `CNT_W`, default 8: match counter width; legal range 1..32.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `en`  in  1  `din` valid this cycle; a bit is accepted on an edge with `en`=1.
- `din`  in  1  serial data bit.
- `cfg_load`  in  1  load `cfg_pattern` and `cfg_overlap`, flush history.
- `cfg_pattern`  in  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
- `cfg_overlap`  in  1  new mode: 1 = overlapping, 0 = non-overlapping.
- `clr_cnt`  in  1  synchronous clear of `match_cnt` and `cnt_sat`.
- `match`  out  1  registered one-cycle pulse, high after the bit completing a match is accepted.
- `match_cnt`  out  CNT_W  number of matches since last clear, saturating.
- `cnt_sat`  out  1  sticky; set when `match_cnt` reaches all-ones.

## Operation
- State: `pat_q` (PAT_W), `ovl_q` (1), shift window `win` (PAT_W), fill count `fill` (0..PAT_W, width clog2(PAT_W+1)), `match`, `match_cnt`, `cnt_sat`.
- Reset values: `pat_q`=PAT_RST, `ovl_q`=0, `win`=0, `fill`=0, `match`=0, `match_cnt`=0, `cnt_sat`=0.
- Accept (`en`=1, `cfg_load`=0): `win_n` = {win[PAT_W-2:0], din}; `fill_n` = min(fill+1, PAT_W).
- Hit condition: `fill_n`==PAT_W and `win_n`==`pat_q`.
- On hit: `match`<=1; if `ovl_q`=0, `fill`<=0 (next match needs PAT_W fresh bits); if `ovl_q`=1, `fill` stays PAT_W (suffix reuse).
- No hit, or `en`=0: `match`<=0; `en`=0 leaves `win`/`fill` unchanged.
- `cfg_load`=1: `pat_q`<=`cfg_pattern`, `ovl_q`<=`cfg_overlap`, `win`<=0, `fill`<=0, `match`<=0; any `din` with `en`=1 that cycle is discarded. `match_cnt` is not affected.
- Counter: on hit, `match_cnt`<=`match_cnt`+1 unless all-ones (hold). `cnt_sat`<=1 when incremented value is all-ones; stays set until cleared.
- `clr_cnt`=1: `match_cnt`<=0, `cnt_sat`<=0; has priority over a simultaneous hit (result 0, hit not counted); `match` still pulses.
- Pattern compare always uses `pat_q`, never `cfg_pattern` directly.

## Timing
- Latency: bit completing a pattern accepted on edge N; `match`=1 from edge N to edge N+1; `match_cnt` updated at edge N.
- `match` high at most one cycle per accepted bit; back-to-back pulses possible in overlapping mode only when the pattern's period allows it (e.g. all-ones pattern).
- Minimum spacing between non-overlapping matches: PAT_W accepted bits.
- Gaps (`en`=0) of any length do not break a partial match.
- `rst` asserted mid-stream: all outputs 0 immediately (asynchronously); partial match lost; pattern returns to PAT_RST.
- Config change takes effect for bits accepted from the edge after `cfg_load`.

## Test plan
- Reset then defaults (PAT_W=4, PAT_RST=1010, non-overlap), stream 1,0,1,0,1,0,1,0 with `en`=1 -> `match` pulses after bits 4 and 8 only; `match_cnt`=2.
- `cfg_load` with pattern 1010, overlap=1, same stream -> pulses after bits 4,6,8; `match_cnt`=3.
- PAT_W=3, pattern 100, non-overlap, stream 1,0,0,1,0,0,0 with `en` dropped for 3 cycles between bits 2 and 3 -> pulses after bits 3 and 6; no pulse on bit 7.
- CNT_W=2, pattern 1111 overlap=1, 8 ones -> pulses after bits 4..8; `match_cnt` holds 3, `cnt_sat`=1 after the 3rd match; `clr_cnt` coinciding with a hit -> `match_cnt`=0, `cnt_sat`=0, `match`=1.
- Feed 1,0,1 of pattern 1010, assert `rst` mid-cycle, release, feed 0 -> no `match`; all outputs 0 during reset.
- Feed 1,0,1, then `cfg_load` (pattern 0110) with `en`=1,`din`=0 same cycle -> bit discarded, no match; then 0,1,1,0 -> single pulse after 4th bit.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector: runtime-loadable pattern, overlap/non-overlap mode,
// registered one-cycle match pulse and saturating match counter.
module seq_detect_param #(
   parameter int                 PAT_W   = 4,
   parameter logic [PAT_W-1:0]   PAT_RST = PAT_W'(4'b1010),
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   input  logic             clr_cnt,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  pat_q;
   logic              ovl_q;
   logic [PAT_W-1:0]  win_q;
   logic [FILL_W-1:0] fill_q;
   logic              match_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              sat_q;

   logic [PAT_W-1:0]  win_d;
   logic [FILL_W-1:0] fill_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              hit;

   always_comb begin
      win_d   = {win_q[PAT_W-2:0], din};
      fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      cnt_inc = cnt_q + CNT_W'(1);
      // a bit arriving together with cfg_load is discarded, so it can never hit
      hit     = en && !cfg_load && (fill_d == FILL_FULL) && (win_d == pat_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q   <= PAT_RST;
         ovl_q   <= 1'b0;
         win_q   <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         match_q <= hit;
         if (cfg_load) begin
            pat_q  <= cfg_pattern;
            ovl_q  <= cfg_overlap;
            win_q  <= '0;
            fill_q <= '0;
         end else if (en) begin
            win_q  <= win_d;
            // non-overlapping mode demands PAT_W fresh bits after every match
            fill_q <= (hit && !ovl_q) ? '0 : fill_d;
         end
         if (clr_cnt) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
         end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == '1) sat_q <= 1'b1;
         end
      end
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (4-bit/8-bit cnt, 3-bit pattern, 2-bit cnt)
// checked every cycle against a bit-history reference model; directed cases then random.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] en = '0, din = '0, ld = '0, ovl = '0, clr = '0;
   logic [3:0] p0 = '0, p2 = '0;
   logic [2:0] p1 = '0;

   logic [2:0] m_o, s_o;
   logic [7:0] c0, c1;
   logic [1:0] c2;

   always #5 clk = ~clk;

   seq_detect_param u0 (
      .clk(clk), .rst(rst), .en(en[0]), .din(din[0]), .cfg_load(ld[0]),
      .cfg_pattern(p0), .cfg_overlap(ovl[0]), .clr_cnt(clr[0]),
      .match(m_o[0]), .match_cnt(c0), .cnt_sat(s_o[0]));

   seq_detect_param #(.PAT_W(3), .PAT_RST(3'b100), .CNT_W(8)) u1 (
      .clk(clk), .rst(rst), .en(en[1]), .din(din[1]), .cfg_load(ld[1]),
      .cfg_pattern(p1), .cfg_overlap(ovl[1]), .clr_cnt(clr[1]),
      .match(m_o[1]), .match_cnt(c1), .cnt_sat(s_o[1]));

   seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1010), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en[2]), .din(din[2]), .cfg_load(ld[2]),
      .cfg_pattern(p2), .cfg_overlap(ovl[2]), .clr_cnt(clr[2]),
      .match(m_o[2]), .match_cnt(c2), .cnt_sat(s_o[2]));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: bit history as a shift value plus count of bits since last flush
   int               pw[3]   = '{4, 3, 4};
   int               cmax[3] = '{255, 255, 3};
   longint unsigned  mpat[3], sh[3];
   int               nb[3], mcnt[3], pc[3];
   bit               movl[3], msat[3], mmatch[3];

   task automatic model_reset();
      mpat = '{64'hA, 64'h4, 64'hA};
      for (int m = 0; m < 3; m++) begin
         movl[m] = 0; sh[m] = 0; nb[m] = 0; mcnt[m] = 0; msat[m] = 0; mmatch[m] = 0;
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 3; m++) begin
         bit hit;
         longint unsigned mask, cfgv;
         hit  = 0;
         mask = (64'd1 << pw[m]) - 1;
         cfgv = (m == 0) ? 64'(p0) : (m == 1) ? 64'(p1) : 64'(p2);
         if (ld[m]) begin
            mpat[m] = cfgv; movl[m] = ovl[m]; sh[m] = 0; nb[m] = 0;
         end else if (en[m]) begin
            sh[m] = ((sh[m] << 1) | 64'(din[m])) & mask;
            nb[m]++;
            if (nb[m] >= pw[m] && sh[m] == mpat[m]) begin
               hit = 1;
               if (!movl[m]) nb[m] = 0;
            end
         end
         mmatch[m] = hit;
         if (clr[m]) begin
            mcnt[m] = 0; msat[m] = 0;
         end else if (hit && mcnt[m] < cmax[m]) begin
            mcnt[m]++;
            if (mcnt[m] == cmax[m]) msat[m] = 1;
         end
      end
   endtask

   function automatic int cnt_of(int m);
      return (m == 0) ? int'(c0) : (m == 1) ? int'(c1) : int'(c2);
   endfunction

   task automatic check_all();
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("match[%0d]", m), int'(m_o[m]), int'(mmatch[m]));
         chk($sformatf("match_cnt[%0d]", m), cnt_of(m), mcnt[m]);
         chk($sformatf("cnt_sat[%0d]", m), int'(s_o[m]), int'(msat[m]));
         if (m_o[m]) pc[m]++;
      end
   endtask

   // inputs are set at the negedge; one call = one rising edge
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic idle();
      en = '0; din = '0; ld = '0; clr = '0;
   endtask

   task automatic feed(input int m, input bit b);
      idle();
      en[m] = 1'b1; din[m] = b;
      tick();
   endtask

   task automatic async_reset();
      #1 rst = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         chk("rst_match", int'(m_o[m]), 0);
         chk("rst_cnt", cnt_of(m), 0);
         chk("rst_sat", int'(s_o[m]), 0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit s1[8];
      s1 = '{1, 0, 1, 0, 1, 0, 1, 0};
      model_reset();
      pc = '{0, 0, 0};
      #2;
      for (int m = 0; m < 3; m++) begin
         chk("reset_match", int'(m_o[m]), 0);
         chk("reset_cnt", cnt_of(m), 0);
         chk("reset_sat", int'(s_o[m]), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // defaults, non-overlapping 1010
      pc = '{0, 0, 0};
      for (int i = 0; i < 8; i++) feed(0, s1[i]);
      chk("t1_pulses", pc[0], 2);
      chk("t1_cnt", int'(c0), 2);

      // overlapping 1010
      idle(); ld[0] = 1; p0 = 4'b1010; ovl[0] = 1; clr[0] = 1; tick();
      pc = '{0, 0, 0};
      for (int i = 0; i < 8; i++) feed(0, s1[i]);
      chk("t2_pulses", pc[0], 3);
      chk("t2_cnt", int'(c0), 3);

      // 3-bit pattern 100 with an enable gap
      pc = '{0, 0, 0};
      feed(1, 1); feed(1, 0);
      idle(); tick(); tick(); tick();
      feed(1, 0); feed(1, 1); feed(1, 0); feed(1, 0);
      chk("t3_pulses_b6", pc[1], 2);
      feed(1, 0);
      chk("t3_no_b7", int'(m_o[1]), 0);
      chk("t3_cnt", int'(c1), 2);

      // 2-bit counter saturation with overlapping all-ones
      idle(); ld[2] = 1; p2 = 4'b1111; ovl[2] = 1; clr[2] = 1; tick();
      pc = '{0, 0, 0};
      for (int i = 0; i < 8; i++) feed(2, 1);
      chk("t4_pulses", pc[2], 5);
      chk("t4_cnt_hold", int'(c2), 3);
      chk("t4_sat", int'(s_o[2]), 1);
      idle(); en[2] = 1; din[2] = 1; clr[2] = 1; tick();
      chk("t4_clr_cnt", int'(c2), 0);
      chk("t4_clr_sat", int'(s_o[2]), 0);
      chk("t4_clr_match", int'(m_o[2]), 1);

      // async reset mid-stream loses the partial match
      idle(); ld[0] = 1; p0 = 4'b1010; ovl[0] = 0; tick();
      feed(0, 1); feed(0, 0); feed(0, 1);
      async_reset();
      feed(0, 0);
      chk("t5_no_match", int'(m_o[0]), 0);

      // cfg_load discards a simultaneous bit and flushes history
      feed(0, 1); feed(0, 0); feed(0, 1);
      idle(); ld[0] = 1; p0 = 4'b0110; ovl[0] = 0; en[0] = 1; din[0] = 0; tick();
      chk("t6_load_match", int'(m_o[0]), 0);
      pc = '{0, 0, 0};
      feed(0, 0); feed(0, 1); feed(0, 1);
      chk("t6_early", pc[0], 0);
      feed(0, 0);
      chk("t6_pulse", int'(m_o[0]), 1);

      // randomized traffic on all three instances
      for (int i = 0; i < 2500; i++) begin
         for (int m = 0; m < 3; m++) begin
            en[m]  = ($urandom_range(0, 3) != 0);
            din[m] = 1'($urandom_range(0, 1));
            ld[m]  = ($urandom_range(0, 59) == 0);
            ovl[m] = 1'($urandom_range(0, 1));
            clr[m] = ($urandom_range(0, 49) == 0);
         end
         p0 = 4'($urandom_range(0, 15));
         p1 = 3'($urandom_range(0, 7));
         p2 = 4'($urandom_range(0, 15));
         tick();
         if ($urandom_range(0, 299) == 0) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
